imm_ext_ctrl: RTL
=================

IMM_EXT_CTRL -- requirements
Module: imm_ext_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, giving the number of decoded-immediate buffer entries (power of two, minimum 2).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the illegal-opcode counter.
REQ-003 The block SHALL have a port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have a port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have a port flush, input, 1 bit: synchronous discard of all buffered entries.
REQ-006 The block SHALL have a port in_valid, input, 1 bit: the producer presents in_instr.
REQ-007 The block SHALL have a port in_ready, output, 1 bit: the block accepts an instruction this cycle.
REQ-008 The block SHALL have a port in_instr, input, 32 bits: the MIPS instruction word.
REQ-009 The block SHALL have a port out_valid, output, 1 bit: the head entry is valid.
REQ-010 The block SHALL have a port out_ready, input, 1 bit: the consumer takes the head entry.
REQ-011 The block SHALL have a port out_imm, output, 32 bits: the extended immediate.
REQ-012 The block SHALL have a port out_mode, output, 2 bits: 0 zero, 1 sign, 2 lui, 3 none.
REQ-013 The block SHALL have a port out_illegal, output, 1 bit: the head opcode is unsupported.
REQ-014 The block SHALL have a port illegal_cnt, output, CNT_W bits: saturating count of accepted illegal opcodes.

Function
REQ-015 A push SHALL occur on a rising clk edge when in_valid and in_ready are both 1; a pop SHALL occur when out_valid and out_ready are both 1.
REQ-016 in_ready SHALL equal (count < DEPTH), derived from registered state only, so a push is refused when the buffer is full even if a pop occurs in the same cycle.
REQ-017 out_valid SHALL equal (count != 0); out_imm, out_mode and out_illegal SHALL be driven from the head entry.
REQ-018 Latency SHALL be exactly 1 cycle: an instruction pushed at edge N SHALL appear at the head after edge N when the buffer was empty.
REQ-019 Decode SHALL happen at push, on opcode in_instr[31:26], with imm = in_instr[15:0].
REQ-020 Opcodes 0x0C, 0x0D and 0x0E (ANDI, ORI, XORI) SHALL give mode 0 and out_imm = {16'h0000, imm}.
REQ-021 Opcodes 0x04, 0x05, 0x08-0x0B, 0x23 and 0x2B SHALL give mode 1 and out_imm = {16{imm[15]}, imm}.
REQ-022 Opcode 0x0F (LUI) SHALL give mode 2 and out_imm = {imm, 16'h0000}.
REQ-023 Opcodes 0x00, 0x02 and 0x03 SHALL give mode 3 and out_imm = 0, with out_illegal = 0.
REQ-024 Any other opcode SHALL give mode 3, out_imm = 0 and out_illegal = 1.
REQ-025 A push of an illegal opcode SHALL increment illegal_cnt by 1, saturating at all-ones; the counter SHALL NOT be cleared by flush.
REQ-026 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and preserve FIFO order.
REQ-027 Pointers SHALL wrap modulo DEPTH.
REQ-028 While out_valid = 1 and out_ready = 0, all head outputs SHALL hold stable.
REQ-029 flush = 1 SHALL set count to 0 and pointers to 0 at the edge, ignoring any same-cycle push and pop; an illegal opcode pushed in a flush cycle SHALL NOT be counted.

Reset
REQ-030 While rst_n = 0, count, pointers and illegal_cnt SHALL be 0, out_valid SHALL be 0, and in_ready SHALL be 1.
REQ-031 While rst_n = 0, out_imm and out_mode SHALL read 0 and out_illegal SHALL read 0.
REQ-032 Reset asserted mid-transfer SHALL discard all entries immediately, without waiting for a clock edge.

Structure
REQ-033 Opcode constants and mode encodings (MODE_ZERO, MODE_SIGN, MODE_LUI, MODE_NONE) SHALL live in a shared package, imm_ext_pkg.
REQ-034 Extension arithmetic SHALL be a single combinational sub-module, imm_extender (in: imm[15:0] and mode; out: 32 bits), instantiated at the buffer write port.

Verification
REQ-035 Push ORI imm=0x8001 on an empty buffer -> one cycle later out_valid=1, out_imm=0x00008001, out_mode=0.
REQ-036 Push ADDI imm=0x8001, then LUI imm=0x1234, with out_ready=0 -> in_ready=0 after 2 pushes; heads read 0xFFFF8001/mode 1, then 0x12340000/mode 2, in order.
REQ-037 Full buffer with out_ready=1 and in_valid=1 -> the push is refused that cycle and accepted the next cycle; no entry is lost or duplicated.
REQ-038 Push opcode 0x3F 300 times (CNT_W=8) -> out_illegal=1 on each entry and illegal_cnt saturates at 255.
REQ-039 Two entries buffered, then flush=1 with a same-cycle push -> out_valid=0 and count=0 next cycle; illegal_cnt is unchanged.
REQ-040 rst_n pulsed low between edges while 1 entry is buffered -> out_valid drops at once and in_ready=1.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared opcode constants, extension modes and the buffer entry layout for the
// MIPS immediate-extension controller.
package imm_ext_pkg;

    typedef enum logic [1:0] {
        MODE_ZERO = 2'd0,
        MODE_SIGN = 2'd1,
        MODE_LUI  = 2'd2,
        MODE_NONE = 2'd3
    } imm_mode_e;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    typedef struct packed {
        imm_mode_e mode;
        logic      illegal;
    } dec_t;

    typedef struct packed {
        logic [31:0] imm;
        imm_mode_e   mode;
        logic        illegal;
    } entry_t;

    function automatic dec_t decode_op(input logic [5:0] op);
        dec_t d;
        d.mode    = MODE_NONE;
        d.illegal = 1'b0;
        case (op)
            OP_ANDI, OP_ORI, OP_XORI:                d.mode = MODE_ZERO;
            OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
            OP_SLTI, OP_SLTIU, OP_LW, OP_SW:         d.mode = MODE_SIGN;
            OP_LUI:                                  d.mode = MODE_LUI;
            OP_SPECIAL, OP_J, OP_JAL:                d.mode = MODE_NONE;
            default:                                 d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/imm_extender.sv
// Combinational 16->32 immediate extension selected by mode; zero latency,
// no flow control.
module imm_extender
    import imm_ext_pkg::*;
(
    input  logic [15:0] i_imm,
    input  imm_mode_e   i_mode,
    output logic [31:0] o_imm
);

    always_comb begin
        o_imm = '0;
        case (i_mode)
            MODE_ZERO: o_imm = {16'h0000, i_imm};
            MODE_SIGN: o_imm = {{16{i_imm[15]}}, i_imm};
            MODE_LUI:  o_imm = {i_imm, 16'h0000};
            default:   o_imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_ext_ctrl.sv
// Decodes MIPS immediates at push into a DEPTH-entry valid/ready buffer; 1-cycle latency.
// in_ready depends only on registered occupancy, so a full buffer refuses a push even on a pop cycle.
module imm_ext_ctrl
    import imm_ext_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_imm,
    output logic [1:0]       out_mode,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CNT_W-1:0] r_ill_cnt;
    entry_t           r_mem [DEPTH];

    logic        w_push;
    logic        w_pop;
    dec_t        w_dec;
    logic [31:0] w_ext_imm;
    entry_t      w_head;

    assign in_ready  = (r_count < FULL_CNT);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_ready & ~flush;
    assign w_dec     = decode_op(in_instr[31:26]);

    imm_extender u_ext (
        .i_imm  (in_instr[15:0]),
        .i_mode (w_dec.mode),
        .o_imm  (w_ext_imm)
    );

    // Storage is not reset; the head is masked to zero whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{imm: w_ext_imm, mode: w_dec.mode, illegal: w_dec.illegal};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Counts accepted illegal pushes only; flush neither clears it nor lets a push count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ill_cnt <= '0;
        end else if (w_push && w_dec.illegal && (r_ill_cnt != '1)) begin
            r_ill_cnt <= r_ill_cnt + CNT_W'(1);
        end
    end

    assign w_head      = out_valid ? r_mem[r_rd_ptr] : '0;
    assign out_imm     = w_head.imm;
    assign out_mode    = w_head.mode;
    assign out_illegal = w_head.illegal;
    assign illegal_cnt = r_ill_cnt;

endmodule
